fixed_mult_pipe: RTL and testbench

//  Pipelined, parametrised signed fixed-point multiplier (default Q24.8) for the linear-regressor datapath.

---
 rtl/fixed_pkg.sv | 26 ++
 rtl/fixed_mult_pipe_if.sv | 30 +++
 rtl/fixed_round_sat.sv | 45 ++++
 rtl/fixed_mult_pipe.sv | 116 +++++++++++
 tb/tb_fixed_mult_pipe.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fixed_pkg.sv
// Shared fixed-point definitions for the regressor datapath: rounding modes,
// pipeline latency and signed range helpers.
package fixed_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  localparam int FIXED_LAT = 3;
  localparam int FX_MAX_W  = 128;

  // Range limits are returned wide so callers can truncate to their own width.
  function automatic logic signed [FX_MAX_W-1:0] fx_max(input int data_w);
    logic signed [FX_MAX_W-1:0] one;
    one = FX_MAX_W'(1);
    return (one <<< (data_w - 1)) - one;
  endfunction

  function automatic logic signed [FX_MAX_W-1:0] fx_min(input int data_w);
    logic signed [FX_MAX_W-1:0] one;
    one = FX_MAX_W'(1);
    return -(one <<< (data_w - 1));
  endfunction

endpackage

// File: rtl/fixed_mult_pipe_if.sv
// Operand/result handshake bundle for the pipelined fixed-point multiplier.
// The master drives operands and accepts results; the slave is the multiplier.
interface fixed_mult_pipe_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] a_in;
  logic signed [DATA_W-1:0] b_in;
  logic [TAG_W-1:0]         tag_in;
  logic                     round_mode;
  logic                     sat_en;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] p_out;
  logic [TAG_W-1:0]         tag_out;
  logic                     ovf_out;
  logic                     unf_out;

  modport master (
    output in_valid, a_in, b_in, tag_in, round_mode, sat_en, out_ready,
    input  in_ready, out_valid, p_out, tag_out, ovf_out, unf_out
  );

  modport slave (
    input  in_valid, a_in, b_in, tag_in, round_mode, sat_en, out_ready,
    output in_ready, out_valid, p_out, tag_out, ovf_out, unf_out
  );
endinterface

// File: rtl/fixed_round_sat.sv
// Combinational rescale of a full-width signed product back to the operand
// Q format: optional half-up rounding, arithmetic shift, range flags, clamp.
module fixed_round_sat
  import fixed_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8
) (
  input  logic signed [2*DATA_W-1:0] full,
  input  round_mode_e                round_mode,
  input  logic                       sat_en,
  output logic signed [DATA_W-1:0]   p,
  output logic                       ovf,
  output logic                       unf
);
  localparam int PW = 2 * DATA_W;
  localparam logic signed [PW-1:0] MAX_F = PW'(fx_max(DATA_W));
  localparam logic signed [PW-1:0] MIN_F = PW'(fx_min(DATA_W));
  localparam logic signed [PW-1:0] HALF  = PW'(1) <<< (FRAC_W - 1);

  // The half-LSB add cannot overflow PW bits: |a*b| <= 2^(PW-2).
  function automatic logic signed [PW-1:0] round_fn(input logic signed [PW-1:0] x,
                                                    input round_mode_e m);
    return ((m == RND_HALF_UP) ? x + HALF : x) >>> FRAC_W;
  endfunction

  function automatic logic signed [DATA_W-1:0] sat_fn(input logic signed [PW-1:0] s,
                                                      input logic sat,
                                                      input logic o,
                                                      input logic u);
    if (sat && o) return MAX_F[DATA_W-1:0];
    if (sat && u) return MIN_F[DATA_W-1:0];
    return s[DATA_W-1:0];
  endfunction

  logic signed [PW-1:0] s;

  always_comb begin
    s   = round_fn(full, round_mode);
    ovf = (s > MAX_F);
    unf = (s < MIN_F);
    p   = sat_fn(s, sat_en, ovf, unf);
  end

endmodule

// File: rtl/fixed_mult_pipe.sv
// Three-stage signed fixed-point multiplier with valid/ready backpressure,
// selectable rounding and saturation, and sticky range status.
module fixed_mult_pipe
  import fixed_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 8,
  parameter int TAG_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  fixed_mult_pipe_if.slave bus,
  input  logic             sticky_clr,
  output logic             ovf_sticky,
  output logic             unf_sticky
);
  localparam int PW = 2 * DATA_W;

  logic vld_p0, vld_p1, vld_p2;
  logic adv_p0, adv_p1, adv_p2;
  logic xfer_out;

  logic signed [DATA_W-1:0] a_p0, b_p0;
  logic [TAG_W-1:0]         tag_p0, tag_p1, tag_p2;
  round_mode_e              rnd_p0, rnd_p1;
  logic                     sat_p0, sat_p1;
  logic signed [PW-1:0]     full_p1;

  logic signed [DATA_W-1:0] p_p2;
  logic                     ovf_p2, unf_p2;

  logic signed [DATA_W-1:0] rs_p;
  logic                     rs_ovf, rs_unf;

  // A stage may load when it is empty or its content moves on this edge.
  always_comb begin
    adv_p2   = ~vld_p2 | bus.out_ready;
    adv_p1   = ~vld_p1 | adv_p2;
    adv_p0   = ~vld_p0 | adv_p1;
    xfer_out = vld_p2 & bus.out_ready;
  end

  assign bus.in_ready  = adv_p0;
  assign bus.out_valid = vld_p2;
  assign bus.p_out     = p_p2;
  assign bus.tag_out   = tag_p2;
  assign bus.ovf_out   = ovf_p2;
  assign bus.unf_out   = unf_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      if (adv_p0) vld_p0 <= bus.in_valid;
      if (adv_p1) vld_p1 <= vld_p0;
      if (adv_p2) vld_p2 <= vld_p1;
    end
  end

  // S1: operands and per-pair modes
  always_ff @(posedge clk) begin
    if (adv_p0 && bus.in_valid) begin
      a_p0   <= bus.a_in;
      b_p0   <= bus.b_in;
      tag_p0 <= bus.tag_in;
      rnd_p0 <= round_mode_e'(bus.round_mode);
      sat_p0 <= bus.sat_en;
    end
  end

  // S2: full-width product
  always_ff @(posedge clk) begin
    if (adv_p1 && vld_p0) begin
      full_p1 <= PW'(a_p0) * PW'(b_p0);
      tag_p1  <= tag_p0;
      rnd_p1  <= rnd_p0;
      sat_p1  <= sat_p0;
    end
  end

  fixed_round_sat #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_round_sat (
    .full       (full_p1),
    .round_mode (rnd_p1),
    .sat_en     (sat_p1),
    .p          (rs_p),
    .ovf        (rs_ovf),
    .unf        (rs_unf)
  );

  // S3: visible result and status; held while downstream stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_p2       <= '0;
      tag_p2     <= '0;
      ovf_p2     <= 1'b0;
      unf_p2     <= 1'b0;
      ovf_sticky <= 1'b0;
      unf_sticky <= 1'b0;
    end else begin
      if (adv_p2 && vld_p1) begin
        p_p2   <= rs_p;
        tag_p2 <= tag_p1;
        ovf_p2 <= rs_ovf;
        unf_p2 <= rs_unf;
      end
      ovf_sticky <= (ovf_sticky & ~sticky_clr) | (xfer_out & ovf_p2);
      unf_sticky <= (unf_sticky & ~sticky_clr) | (xfer_out & unf_p2);
    end
  end

endmodule

// File: tb/tb_fixed_mult_pipe.sv
// Randomised and directed bench for fixed_mult_pipe (Q24.8) against an
// integer-arithmetic reference model.
module tb_fixed_mult_pipe;
  import fixed_pkg::*;

  localparam int DATA_W = 32;
  localparam int FRAC_W = 8;
  localparam int TAG_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sticky_clr = 1'b0;
  logic ovf_sticky, unf_sticky;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] p;
    logic        ovf;
    logic        unf;
  } res_t;

  fixed_mult_pipe_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

  fixed_mult_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sticky_clr (sticky_clr),
    .ovf_sticky (ovf_sticky),
    .unf_sticky (unf_sticky)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: exact integer product, optional +half, floor shift, range test.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input bit rm, input bit sat);
    res_t r;
    longint sa, sb, full, s, maxv, minv;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    full = sa * sb;
    if (rm) full = full + (longint'(1) << (FRAC_W - 1));
    s    = full >>> FRAC_W;
    maxv = (longint'(1) << (DATA_W - 1)) - 1;
    minv = -(longint'(1) << (DATA_W - 1));
    r.ovf = (s > maxv);
    r.unf = (s < minv);
    if (sat && r.ovf)      r.p = 32'(maxv);
    else if (sat && r.unf) r.p = 32'(minv);
    else                   r.p = 32'(s);
    return r;
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1, 2: return {{16{r[15]}}, r[15:0]};
      default: begin
        case (r[1:0])
          2'd0: return 32'h7FFF_FFFF;
          2'd1: return 32'h8000_0000;
          2'd2: return 32'hFFFF_FFFF;
          default: return 32'h0000_0100;
        endcase
      end
    endcase
  endfunction

  // Presents one pair; returns one cycle after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                      input bit rm, input bit sat, output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    bus.a_in = a; bus.b_in = b; bus.tag_in = tag;
    bus.round_mode = rm; bus.sat_en = sat;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (bus.in_ready) begin
      @(posedge clk); #1; ok = 1'b1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Waits for a result with out_ready high, captures it, lets it transfer.
  task automatic get_result(output res_t r, output logic [3:0] tag, output int edges, output bit ok);
    edges = 0;
    ok = 1'b0;
    r.p = '0; r.ovf = 1'b0; r.unf = 1'b0; tag = '0;
    while (!bus.out_valid && edges < 20) begin
      @(posedge clk); #1; edges++;
    end
    if (bus.out_valid) begin
      ok = 1'b1;
      r.p = bus.p_out; r.ovf = bus.ovf_out; r.unf = bus.unf_out; tag = bus.tag_out;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_clear();
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.a_in = 0; bus.b_in = 0; bus.tag_in = 0;
    bus.round_mode = 0; bus.sat_en = 0; bus.out_ready = 1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    n_checks += 7;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    if (bus.p_out !== 32'h0) begin n_fail++; $display("FAIL reset_p_out: got %h want 00000000", bus.p_out); end
    if (bus.tag_out !== 4'h0) begin n_fail++; $display("FAIL reset_tag_out: got %h want 0", bus.tag_out); end
    if (bus.ovf_out !== 1'b0 || bus.unf_out !== 1'b0) begin n_fail++; $display("FAIL reset_flags: got ovf=%b unf=%b want 0 0", bus.ovf_out, bus.unf_out); end
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_ovf_sticky: got %b want 0", ovf_sticky); end
    if (unf_sticky !== 1'b0) begin n_fail++; $display("FAIL reset_unf_sticky: got %b want 0", unf_sticky); end
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    res_t r; logic [3:0] tg; int e; bit ok1, ok2;
    send(32'h180, 32'h200, 4'h5, 1'b0, 1'b1, ok1);
    get_result(r, tg, e, ok2);
    n_checks += 5;
    if (!(ok1 && ok2)) begin n_fail++; $display("FAIL basic_handshake: got ok=%b%b want 11", ok1, ok2); end
    if (r.p !== 32'h300) begin n_fail++; $display("FAIL basic_p: got %h want 00000300", r.p); end
    if (r.ovf !== 1'b0 || r.unf !== 1'b0) begin n_fail++; $display("FAIL basic_flags: got %b%b want 00", r.ovf, r.unf); end
    if (tg !== 4'h5) begin n_fail++; $display("FAIL basic_tag: got %h want 5", tg); end
    if (e + 1 != FIXED_LAT) begin n_fail++; $display("FAIL basic_latency: got %0d want %0d", e + 1, FIXED_LAT); end
  endtask

  task automatic test_rounding();
    logic [31:0] ta [4] = '{32'h1, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    bit          tr [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] tx [4] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h0};
    res_t r; logic [3:0] tg; int e; bit ok1, ok2;
    for (int i = 0; i < 4; i++) begin
      send(ta[i], 32'h80, 4'(i), tr[i], 1'b1, ok1);
      get_result(r, tg, e, ok2);
      n_checks += 2;
      if (!(ok1 && ok2) || r.p !== tx[i]) begin n_fail++; $display("FAIL round_p[%0d]: got %h want %h", i, r.p, tx[i]); end
      if (r.ovf !== 1'b0 || r.unf !== 1'b0) begin n_fail++; $display("FAIL round_flags[%0d]: got %b%b want 00", i, r.ovf, r.unf); end
    end
  endtask

  task automatic test_overflow();
    res_t r; logic [3:0] tg; int e; bit ok1, ok2;
    send(32'h7FFF_FF00, 32'h200, 4'h9, 1'b0, 1'b1, ok1);
    get_result(r, tg, e, ok2);
    n_checks += 3;
    if (!(ok1 && ok2) || r.p !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL ovf_sat_p: got %h want 7fffffff", r.p); end
    if (r.ovf !== 1'b1 || r.unf !== 1'b0) begin n_fail++; $display("FAIL ovf_sat_flags: got %b%b want 10", r.ovf, r.unf); end
    if (ovf_sticky !== 1'b1 || unf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky_set: got %b%b want 10", ovf_sticky, unf_sticky); end
    send(32'h7FFF_FF00, 32'h200, 4'hA, 1'b0, 1'b0, ok1);
    get_result(r, tg, e, ok2);
    n_checks += 2;
    if (!(ok1 && ok2) || r.p !== 32'hFFFF_FE00) begin n_fail++; $display("FAIL ovf_wrap_p: got %h want fffffe00", r.p); end
    if (r.ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_wrap_flag: got %b want 1", r.ovf); end
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky_hold: got %b want 1", ovf_sticky); end
    pulse_clear();
    n_checks++;
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL ovf_sticky_clear: got %b want 0", ovf_sticky); end
  endtask

  task automatic test_underflow();
    res_t r; logic [3:0] tg; int e; bit ok1, ok2;
    send(32'h8000_0000, 32'h200, 4'h3, 1'b0, 1'b1, ok1);
    get_result(r, tg, e, ok2);
    n_checks += 3;
    if (!(ok1 && ok2) || r.p !== 32'h8000_0000) begin n_fail++; $display("FAIL unf_p: got %h want 80000000", r.p); end
    if (r.unf !== 1'b1 || r.ovf !== 1'b0) begin n_fail++; $display("FAIL unf_flags: got ovf=%b unf=%b want 0 1", r.ovf, r.unf); end
    if (unf_sticky !== 1'b1) begin n_fail++; $display("FAIL unf_sticky_set: got %b want 1", unf_sticky); end
    send(32'h8000_0000, 32'h8000_0000, 4'h4, 1'b0, 1'b1, ok1);
    get_result(r, tg, e, ok2);
    n_checks += 2;
    if (!(ok1 && ok2) || r.p !== 32'h7FFF_FFFF) begin n_fail++; $display("FAIL minmin_p: got %h want 7fffffff", r.p); end
    if (r.ovf !== 1'b1 || r.unf !== 1'b0) begin n_fail++; $display("FAIL minmin_flags: got %b%b want 10", r.ovf, r.unf); end
    pulse_clear();
  endtask

  task automatic test_sticky_collision();
    bit ok1; int n;
    n = 0;
    bus.out_ready = 1'b0;
    send(32'h7FFF_FF00, 32'h200, 4'h1, 1'b0, 1'b1, ok1);
    while (!bus.out_valid && n < 20) begin @(posedge clk); #1; n++; end
    n_checks += 2;
    if (!ok1 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL collide_setup: got out_valid=%b want 1", bus.out_valid); end
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL collide_pre_sticky: got %b want 0", ovf_sticky); end
    sticky_clr = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    n_checks += 2;
    if (ovf_sticky !== 1'b1) begin n_fail++; $display("FAIL collide_set_wins: got %b want 1", ovf_sticky); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL collide_consumed: got out_valid=%b want 0", bus.out_valid); end
    pulse_clear();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sa [8], sb [8];
    bit          srm [8], ssat [8];
    res_t        exp_q [$];
    logic [3:0]  tag_q [$];
    res_t        er;
    logic [3:0]  et, ht;
    logic [31:0] hp;
    int idx, got, cyc;
    bit fire_in, fire_out, held, saw_block;
    for (int i = 0; i < 8; i++) begin
      sa[i] = rand_operand(); sb[i] = rand_operand();
      srm[i] = 1'($urandom); ssat[i] = 1'($urandom);
    end
    idx = 0; got = 0; cyc = 0; held = 0; saw_block = 0; hp = '0; ht = '0;
    while (got < 8 && cyc < 80) begin
      bus.out_ready = !(cyc >= 4 && cyc <= 7);
      if (idx < 8) begin
        bus.in_valid = 1'b1; bus.a_in = sa[idx]; bus.b_in = sb[idx];
        bus.tag_in = 4'(idx + 8); bus.round_mode = srm[idx]; bus.sat_en = ssat[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (bus.in_valid && !bus.in_ready) saw_block = 1'b1;
      fire_in  = bus.in_valid && bus.in_ready;
      fire_out = bus.out_valid && bus.out_ready;
      if (held) begin
        n_checks++;
        if (bus.out_valid !== 1'b1 || bus.p_out !== hp || bus.tag_out !== ht) begin
          n_fail++; $display("FAIL stall_stable: got v=%b p=%h tag=%h want v=1 p=%h tag=%h", bus.out_valid, bus.p_out, bus.tag_out, hp, ht);
        end
      end
      held = bus.out_valid && !bus.out_ready;
      hp = bus.p_out; ht = bus.tag_out;
      if (fire_out) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra: got unexpected result p=%h tag=%h want none", bus.p_out, bus.tag_out);
        end else begin
          er = exp_q.pop_front(); et = tag_q.pop_front();
          if (bus.p_out !== er.p || bus.ovf_out !== er.ovf || bus.unf_out !== er.unf || bus.tag_out !== et) begin
            n_fail++; $display("FAIL b2b_result[%0d]: got p=%h o=%b u=%b tag=%h want p=%h o=%b u=%b tag=%h",
                               got, bus.p_out, bus.ovf_out, bus.unf_out, bus.tag_out, er.p, er.ovf, er.unf, et);
          end
        end
        got++;
      end
      if (fire_in) begin
        exp_q.push_back(model(sa[idx], sb[idx], srm[idx], ssat[idx]));
        tag_q.push_back(4'(idx + 8));
        idx++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    n_checks += 3;
    if (got != 8) begin n_fail++; $display("FAIL b2b_count: got %0d results want 8", got); end
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL b2b_leftover: got %0d pending want 0", exp_q.size()); end
    if (!saw_block) begin n_fail++; $display("FAIL b2b_in_ready_drop: got in_ready never low want low during stall"); end
    pulse_clear();
  endtask

  task automatic test_random();
    res_t r, er; logic [3:0] tg, t; int e; bit ok1, ok2, rm, sat;
    logic [31:0] a, b;
    for (int i = 0; i < 30; i++) begin
      a = rand_operand(); b = rand_operand();
      rm = 1'($urandom); sat = 1'($urandom); t = 4'($urandom);
      er = model(a, b, rm, sat);
      send(a, b, t, rm, sat, ok1);
      get_result(r, tg, e, ok2);
      n_checks++;
      if (!(ok1 && ok2) || r.p !== er.p || r.ovf !== er.ovf || r.unf !== er.unf || tg !== t) begin
        n_fail++; $display("FAIL rand[%0d] a=%h b=%h rm=%b sat=%b: got p=%h o=%b u=%b tag=%h want p=%h o=%b u=%b tag=%h",
                           i, a, b, rm, sat, r.p, r.ovf, r.unf, tg, er.p, er.ovf, er.unf, t);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int seen;
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.round_mode = 1'b0; bus.sat_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.a_in = 32'h7FFF_FF00; bus.b_in = 32'h200; bus.tag_in = 4'(i + 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_checks++;
    if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got out_valid=%b want 1", bus.out_valid); end
    rst_n = 1'b0;
    #1;
    n_checks += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b want 0", bus.out_valid); end
    if (bus.p_out !== 32'h0 || bus.tag_out !== 4'h0) begin n_fail++; $display("FAIL rstmid_outputs: got p=%h tag=%h want 0 0", bus.p_out, bus.tag_out); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    n_checks += 2;
    if (seen != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d results want 0", seen); end
    if (ovf_sticky !== 1'b0) begin n_fail++; $display("FAIL rstmid_sticky: got %b want 0", ovf_sticky); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_overflow();
    test_underflow();
    test_sticky_collision();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
